// File: rtl/icache_refill_ctrl.sv
// rtl/icache_refill_ctrl.sv - L1 instruction cache miss refill sequencer
//
// Purpose:
//    Takes one pending instruction-cache miss at a time, issues a single
//    line-read request to memory, streams the returned beats into the data
//    array, writes the tag array with the valid bit set, then pulses
//    missResolved_o so the hit/miss check stage can let fetch resume.
//
// Optional feature (macro ICACHE_CRITICAL_WORD_FIRST_EN):
//    When defined, the refill starts at the beat holding the missing offset
//    and the data-array slots wrap modulo BEATS from there. When undefined
//    the refill always starts at beat 0.
//
// Ports:
//    clock_i         rising-edge clock
//    reset_i         synchronous active-high reset
//    missValid_i     level, miss pending (only looked at in IDLE)
//    missTag_i       missing tag
//    missIndex_i     missing set index
//    missOffset_i    missing byte offset
//    memReq_o        line read request valid (held until memReqReady_i)
//    memReqAddr_o    64-bit byte address {tag, index, offset field}
//    memReqReady_i   memory accepts the request this cycle
//    memRespValid_i  response beat valid
//    memRespData_i   response beat data
//    lineWrEn_o      data-array beat write strobe
//    lineWrIndex_o   data-array set to write
//    lineWrBeat_o    beat slot within the line (unused MSBs zero)
//    lineWrData_o    beat data to write
//    tagWrEn_o       tag-array write strobe (one cycle)
//    tagWrIndex_o    tag-array set to write
//    tagWrData_o     {valid=1, tag}
//    missResolved_o  one-cycle pulse when the refill is complete
//    busy_o          high in every state other than IDLE

module icache_refill_ctrl #(
   parameter int TAG_WIDTH    = 51,
   parameter int INDEX_WIDTH  = 8,
   parameter int OFFSET_WIDTH = 5,
   parameter int BEAT_WIDTH   = 64
) (
   input  logic                   clock_i,
   input  logic                   reset_i,
   input  logic                   missValid_i,
   input  logic [TAG_WIDTH-1:0]   missTag_i,
   input  logic [INDEX_WIDTH-1:0] missIndex_i,
   input  logic [OFFSET_WIDTH-1:0] missOffset_i,
   output logic                   memReq_o,
   output logic [63:0]            memReqAddr_o,
   input  logic                   memReqReady_i,
   input  logic                   memRespValid_i,
   input  logic [BEAT_WIDTH-1:0]  memRespData_i,
   output logic                   lineWrEn_o,
   output logic [INDEX_WIDTH-1:0] lineWrIndex_o,
   output logic [2:0]             lineWrBeat_o,
   output logic [BEAT_WIDTH-1:0]  lineWrData_o,
   output logic                   tagWrEn_o,
   output logic [INDEX_WIDTH-1:0] tagWrIndex_o,
   output logic [TAG_WIDTH:0]     tagWrData_o,
   output logic                   missResolved_o,
   output logic                   busy_o
);

   // A line is 256 bits; each beat fills one slot of it.
   localparam int BEATS     = 256 / BEAT_WIDTH;
   localparam int BEAT_BITS = (BEATS > 1) ? $clog2(BEATS) : 1;
   // Byte-offset bits that address inside a single beat.
   localparam int BYTE_BITS = OFFSET_WIDTH - BEAT_BITS;

   localparam logic [BEAT_BITS-1:0] LAST_CNT = BEAT_BITS'(BEATS - 1);
   localparam logic [BEAT_BITS-1:0] BEAT_ONE = BEAT_BITS'(1);

   generate
      if (BEAT_WIDTH != 32 && BEAT_WIDTH != 64 && BEAT_WIDTH != 128) begin : g_bad_beat
         $error("icache_refill_ctrl: BEAT_WIDTH must be 32, 64 or 128");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_FILL,
      S_TAG,
      S_RESOLVE
   } state_t;

   state_t                  state;
   logic [TAG_WIDTH-1:0]    tag_q;
   logic [INDEX_WIDTH-1:0]  index_q;
   logic [BEAT_BITS-1:0]    beat_cnt;   // beats accepted so far in FILL
   logic [BEAT_BITS-1:0]    slot_q;     // slot the next accepted beat goes to
   logic [BEAT_BITS-1:0]    start_beat;
   logic [OFFSET_WIDTH-1:0] req_offset;
   logic                    unused_offset;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
   // The upper offset bits select which beat of the line holds the missing word.
   assign start_beat = missOffset_i[OFFSET_WIDTH-1 -: BEAT_BITS];
`else
   assign start_beat = '0;
`endif

   // Offset field of the request address: start beat scaled to bytes, so the
   // bits inside a beat are always zero.
   assign req_offset = OFFSET_WIDTH'(start_beat) << BYTE_BITS;

   // The bits of the miss offset below beat granularity never affect the refill.
   assign unused_offset = ^missOffset_i;

   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state          <= S_IDLE;
         tag_q          <= '0;
         index_q        <= '0;
         beat_cnt       <= '0;
         slot_q         <= '0;
         memReq_o       <= 1'b0;
         memReqAddr_o   <= '0;
         lineWrEn_o     <= 1'b0;
         lineWrIndex_o  <= '0;
         lineWrBeat_o   <= '0;
         lineWrData_o   <= '0;
         tagWrEn_o      <= 1'b0;
         tagWrIndex_o   <= '0;
         tagWrData_o    <= '0;
         missResolved_o <= 1'b0;
         busy_o         <= 1'b0;
      end else begin
         // Beat write strobe is a single-cycle pulse per accepted beat.
         lineWrEn_o <= 1'b0;

         case (state)
            S_IDLE: begin
               // Response beats seen here belong to an aborted refill and
               // are dropped simply by not looking at them.
               if (missValid_i) begin
                  tag_q        <= missTag_i;
                  index_q      <= missIndex_i;
                  slot_q       <= start_beat;
                  beat_cnt     <= '0;
                  memReq_o     <= 1'b1;
                  memReqAddr_o <= 64'({missTag_i, missIndex_i, req_offset});
                  busy_o       <= 1'b1;
                  state        <= S_REQ;
               end
            end

            S_REQ: begin
               // Address was registered on entry and stays put until accepted.
               if (memReqReady_i) begin
                  memReq_o     <= 1'b0;
                  memReqAddr_o <= '0;
                  state        <= S_FILL;
               end
            end

            S_FILL: begin
               if (memRespValid_i) begin
                  lineWrEn_o    <= 1'b1;
                  lineWrIndex_o <= index_q;
                  lineWrBeat_o  <= 3'(slot_q);
                  lineWrData_o  <= memRespData_i;
                  slot_q        <= slot_q + BEAT_ONE;   // wraps modulo BEATS
                  if (beat_cnt == LAST_CNT) begin
                     // The tag write shares the cycle with the last beat write.
                     beat_cnt     <= '0;
                     tagWrEn_o    <= 1'b1;
                     tagWrIndex_o <= index_q;
                     tagWrData_o  <= {1'b1, tag_q};
                     state        <= S_TAG;
                  end else begin
                     beat_cnt <= beat_cnt + BEAT_ONE;
                  end
               end
            end

            S_TAG: begin
               tagWrEn_o      <= 1'b0;
               missResolved_o <= 1'b1;
               state          <= S_RESOLVE;
            end

            S_RESOLVE: begin
               // The checker drops its miss on this edge, so IDLE never
               // re-captures the miss that was just serviced.
               missResolved_o <= 1'b0;
               busy_o         <= 1'b0;
               state          <= S_IDLE;
            end

            default: begin
               memReq_o       <= 1'b0;
               tagWrEn_o      <= 1'b0;
               missResolved_o <= 1'b0;
               busy_o         <= 1'b0;
               state          <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb/tb_icache_refill_ctrl.sv - directed self-checking bench for icache_refill_ctrl

module tb_icache_refill_ctrl;

   logic        clock_i;
   logic        reset_i;
   logic        missValid_i;
   logic [50:0] missTag_i;
   logic [7:0]  missIndex_i;
   logic [4:0]  missOffset_i;
   logic        memReq_o;
   logic [63:0] memReqAddr_o;
   logic        memReqReady_i;
   logic        memRespValid_i;
   logic [63:0] memRespData_i;
   logic        lineWrEn_o;
   logic [7:0]  lineWrIndex_o;
   logic [2:0]  lineWrBeat_o;
   logic [63:0] lineWrData_o;
   logic        tagWrEn_o;
   logic [7:0]  tagWrIndex_o;
   logic [51:0] tagWrData_o;
   logic        missResolved_o;
   logic        busy_o;

   icache_refill_ctrl dut (
      .clock_i        (clock_i),
      .reset_i        (reset_i),
      .missValid_i    (missValid_i),
      .missTag_i      (missTag_i),
      .missIndex_i    (missIndex_i),
      .missOffset_i   (missOffset_i),
      .memReq_o       (memReq_o),
      .memReqAddr_o   (memReqAddr_o),
      .memReqReady_i  (memReqReady_i),
      .memRespValid_i (memRespValid_i),
      .memRespData_i  (memRespData_i),
      .lineWrEn_o     (lineWrEn_o),
      .lineWrIndex_o  (lineWrIndex_o),
      .lineWrBeat_o   (lineWrBeat_o),
      .lineWrData_o   (lineWrData_o),
      .tagWrEn_o      (tagWrEn_o),
      .tagWrIndex_o   (tagWrIndex_o),
      .tagWrData_o    (tagWrData_o),
      .missResolved_o (missResolved_o),
      .busy_o         (busy_o)
   );

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Event log filled by the monitor.
   logic [7:0]  wr_idx  [$];
   logic [2:0]  wr_beat [$];
   logic [63:0] wr_data [$];
   int          wr_cyc  [$];
   int          tag_n;
   int          tag_cyc;
   logic [51:0] tag_data;
   logic [7:0]  tag_idx;
   int          res_n;

   initial begin
      clock_i = 1'b0;
      forever #5 clock_i = ~clock_i;
   end

   always @(posedge clock_i) cyc <= cyc + 1;

   always @(negedge clock_i) begin
      if (lineWrEn_o) begin
         wr_idx.push_back(lineWrIndex_o);
         wr_beat.push_back(lineWrBeat_o);
         wr_data.push_back(lineWrData_o);
         wr_cyc.push_back(cyc);
      end
      if (tagWrEn_o) begin
         tag_n    = tag_n + 1;
         tag_cyc  = cyc;
         tag_data = tagWrData_o;
         tag_idx  = tagWrIndex_o;
      end
      if (missResolved_o) res_n = res_n + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_i);
      #1;
   endtask

   task automatic clear_log();
      wr_idx.delete();
      wr_beat.delete();
      wr_data.delete();
      wr_cyc.delete();
      tag_n = 0;
      tag_cyc = -1;
      tag_data = '0;
      tag_idx = '0;
      res_n = 0;
   endtask

   task automatic check_zero(input string nm);
      check_eq({nm, ".memReq"},   64'(memReq_o),       64'd0);
      check_eq({nm, ".reqAddr"},  memReqAddr_o,        64'd0);
      check_eq({nm, ".lineWrEn"}, 64'(lineWrEn_o),     64'd0);
      check_eq({nm, ".lineIdx"},  64'(lineWrIndex_o),  64'd0);
      check_eq({nm, ".lineBeat"}, 64'(lineWrBeat_o),   64'd0);
      check_eq({nm, ".lineData"}, lineWrData_o,        64'd0);
      check_eq({nm, ".tagWrEn"},  64'(tagWrEn_o),      64'd0);
      check_eq({nm, ".tagIdx"},   64'(tagWrIndex_o),   64'd0);
      check_eq({nm, ".tagData"},  64'(tagWrData_o),    64'd0);
      check_eq({nm, ".resolved"}, 64'(missResolved_o), 64'd0);
      check_eq({nm, ".busy"},     64'(busy_o),         64'd0);
   endtask

   // One full miss: request (with rd cycles of backpressure), four beats each
   // preceded by gap idle cycles, then tag write and resolve pulse.
   task automatic do_refill(input string nm, input logic [50:0] tg, input logic [7:0] ix,
                            input logic [4:0] of, input int rd, input int gap,
                            input logic [63:0] base);
      int          c0;
      int          ck;
      bit          seen;
      logic [1:0]  start;
      logic [63:0] exp_addr;
      logic [1:0]  s;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      start    = of[4:3];
      exp_addr = {tg, ix, of[4:3], 3'b000};
`else
      start    = 2'd0;
      exp_addr = {tg, ix, 5'd0};
`endif
      clear_log();
      missTag_i     = tg;
      missIndex_i   = ix;
      missOffset_i  = of;
      missValid_i   = 1'b1;
      memReqReady_i = 1'b0;
      step();
      c0 = cyc;
      check_eq({nm, ".memReq"}, 64'(memReq_o), 64'd1);
      check_eq({nm, ".addr"},   memReqAddr_o,  exp_addr);
      check_eq({nm, ".busy"},   64'(busy_o),   64'd1);
      for (int k = 0; k < rd; k++) begin
         step();
         check_eq({nm, ".memReqHeld"}, 64'(memReq_o), 64'd1);
         check_eq({nm, ".addrHeld"},   memReqAddr_o,  exp_addr);
      end
      memReqReady_i = 1'b1;
      step();
      memReqReady_i = 1'b0;
      check_eq({nm, ".reqDropped"}, 64'(memReq_o), 64'd0);
      for (int b = 0; b < 4; b++) begin
         for (int g = 0; g < gap; g++) step();
         memRespValid_i = 1'b1;
         memRespData_i  = base + 64'(b);
         step();
         memRespValid_i = 1'b0;
      end
      seen = 1'b0;
      ck   = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         if (missResolved_o) begin
            seen = 1'b1;
            ck   = cyc;
         end else begin
            step();
         end
      end
      missValid_i = 1'b0;
      check_eq({nm, ".resolveSeen"}, 64'(seen), 64'd1);
      // Pulse cycle, counting the cycle in which the miss is sampled as 1.
      check_eq({nm, ".latency"}, 64'(ck - c0 + 2), 64'(1 + (1 + rd) + 4 * (gap + 1) + 1 + 1));
      step();
      step();
      check_eq({nm, ".idleBusy"}, 64'(busy_o),          64'd0);
      check_eq({nm, ".writes"},   64'(wr_idx.size()),   64'd4);
      check_eq({nm, ".tagWrites"}, 64'(tag_n),          64'd1);
      check_eq({nm, ".resolves"}, 64'(res_n),           64'd1);
      check_eq({nm, ".tagData"},  64'(tag_data),        64'({1'b1, tg}));
      check_eq({nm, ".tagIdx"},   64'(tag_idx),         64'(ix));
      if (wr_cyc.size() == 4)
         check_eq({nm, ".tagWithLast"}, 64'(tag_cyc), 64'(wr_cyc[3]));
      for (int b = 0; b < wr_idx.size() && b < 4; b++) begin
         s = start + 2'(b);
         check_eq($sformatf("%s.wr%0d.idx", nm, b),  64'(wr_idx[b]),  64'(ix));
         check_eq($sformatf("%s.wr%0d.slot", nm, b), 64'(wr_beat[b]), 64'(s));
         check_eq($sformatf("%s.wr%0d.data", nm, b), wr_data[b],      base + 64'(b));
      end
   endtask

   initial begin
      reset_i        = 1'b1;
      missValid_i    = 1'b0;
      missTag_i      = '0;
      missIndex_i    = '0;
      missOffset_i   = '0;
      memReqReady_i  = 1'b0;
      memRespValid_i = 1'b0;
      memRespData_i  = '0;
      clear_log();
      step();
      step();
      check_zero("reset");
      reset_i = 1'b0;
      step();

      do_refill("basic",  51'd4, 8'd10, 5'd5, 0, 0, 64'hA0A0_0000_0000_0000);
      check_eq("basic.addrValue", {51'd4, 8'd10, 5'd0}, 64'h8140);
      do_refill("bp",     51'h1234_5678_9ABC, 8'hFF, 5'd0, 3, 0, 64'hB0B0_1111_0000_0000);
      do_refill("gaps",   51'd3, 8'd0, 5'd31, 0, 2, 64'hC0C0_2222_0000_0000);

      // Reset in the middle of FILL after two beats.
      clear_log();
      missTag_i     = 51'd9;
      missIndex_i   = 8'd5;
      missOffset_i  = 5'd0;
      missValid_i   = 1'b1;
      step();
      memReqReady_i = 1'b1;
      step();
      memReqReady_i = 1'b0;
      for (int b = 0; b < 2; b++) begin
         memRespValid_i = 1'b1;
         memRespData_i  = 64'hD0D0_0000_0000_0000 + 64'(b);
         step();
      end
      memRespValid_i = 1'b0;
      missValid_i    = 1'b0;
      reset_i        = 1'b1;
      step();
      check_zero("midrst");
      reset_i = 1'b0;
      for (int b = 2; b < 4; b++) begin
         memRespValid_i = 1'b1;
         memRespData_i  = 64'hD0D0_0000_0000_0000 + 64'(b);
         step();
      end
      memRespValid_i = 1'b0;
      step();
      step();
      check_eq("midrst.writes",    64'(wr_idx.size()), 64'd2);
      check_eq("midrst.tagWrites", 64'(tag_n),         64'd0);
      check_eq("midrst.resolves",  64'(res_n),         64'd0);
      check_eq("midrst.busy",      64'(busy_o),        64'd0);
      do_refill("after",  51'd9, 8'd5, 5'd0, 0, 0, 64'hE0E0_3333_0000_0000);

      do_refill("cwf",    51'd4, 8'd10, 5'd20, 0, 0, 64'hF0F0_4444_0000_0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
